ps2_host_tx: RTL
================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 5000, SHALL set the FPGAClk cycles PS2Clk is held low before the start bit (100 us at 50 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 750000, SHALL set the watchdog limit in FPGAClk cycles (15 ms at 50 MHz).
REQ-003 FPGAClk  in  1  SHALL be the single system clock; all flops on its rising edge.
REQ-004 rst  in  1  SHALL be the synchronous, active-low reset.
REQ-005 tx_data  in  8  SHALL be the command byte, sampled in the cycle tx_start is accepted.
REQ-006 tx_start  in  1  SHALL be a one-cycle request to transmit.
REQ-007 PS2Clk_in, PS2Data_in  in  1 each  SHALL be the raw, asynchronous PS/2 line levels.
REQ-008 PS2Clk_oe, PS2Data_oe  out  1 each  SHALL request the open-drain pad to pull the line low when 1.
REQ-009 busy  out  1  SHALL be high whenever state is not IDLE.
REQ-010 done  out  1  SHALL pulse high for one cycle at transfer end.
REQ-011 err  out  1  SHALL be valid only while done is high; 1 = no ACK or timeout.

Function
REQ-012 PS2Clk_in and PS2Data_in SHALL each pass through a two-flop synchronizer; a PS2Clk falling edge SHALL be a registered synchronized 1 followed by synchronized 0.
REQ-013 States SHALL be IDLE, INHIBIT, START, SHIFT, PARITY, STOP, ACK.
REQ-014 In IDLE both oe outputs SHALL be 0; tx_start SHALL latch tx_data, compute odd parity (~^tx_data), clear the edge counter, and enter INHIBIT next cycle.
REQ-015 tx_start while busy SHALL be ignored, with no change to the latched byte.
REQ-016 INHIBIT SHALL hold PS2Clk_oe=1, PS2Data_oe=0 for exactly INHIBIT_CYCLES cycles, then enter START.
REQ-017 START SHALL set PS2Clk_oe=0 and PS2Data_oe=1 (start bit 0), and wait for the first PS2Clk falling edge.
REQ-018 On falling edges 1-8, SHALL drive bit (n-1), LSB first: PS2Data_oe = ~bit, changing in the cycle after edge detect; after edge 8 enter PARITY.
REQ-019 Falling edge 9 SHALL drive the parity bit; falling edge 10 SHALL release data (PS2Data_oe=0, stop bit) and enter ACK.
REQ-020 ACK SHALL sample synchronized PS2Data at falling edge 11: 0 -> done=1, err=0; 1 -> done=1, err=1; then return to IDLE.
REQ-021 PS2Clk_oe SHALL be 0 in every state other than INHIBIT.
REQ-022 Falling edges detected in IDLE or INHIBIT SHALL be ignored and not counted (device-to-host traffic does not disturb the transmitter).
REQ-023 The edge counter SHALL be 4 bits, range 0-11, and SHALL never wrap within a transfer.
REQ-024 done SHALL never be asserted while busy is low in the following cycle's sense: busy falls in the same cycle done is high.

Reset
REQ-025 While rst=0 at a clock edge: state=IDLE, PS2Clk_oe=0, PS2Data_oe=0, busy=0, done=0, err=0, counters and synchronizers cleared (sync flops to 1).
REQ-026 Reset mid-transfer SHALL release both lines in the next cycle with no done pulse.

Configuration
REQ-027 With macro PS2_TX_TIMEOUT_EN defined, a watchdog SHALL count cycles from leaving INHIBIT; on reaching TIMEOUT_CYCLES before REQ-020 completes, release both lines, pulse done with err=1, and return to IDLE.
REQ-028 Without PS2_TX_TIMEOUT_EN, no watchdog logic SHALL exist and START..ACK SHALL wait indefinitely for edges.

Verification (INHIBIT_CYCLES=16, TIMEOUT_CYCLES=2000 in bench)
REQ-029 tx_data=0xED, device model clocks 11 edges and pulls data low at edge 11 -> sampled bits 1,0,1,1,0,1,1,1, parity 1, stop 1; done=1, err=0.
REQ-030 tx_data=0x00, device leaves data high at edge 11 -> parity 1 transmitted, done=1, err=1.
REQ-031 tx_start pulse -> PS2Clk_oe high exactly 16 cycles, then PS2Data_oe=1 with PS2Clk_oe=0.
REQ-032 Second tx_start with tx_data=0x55 during SHIFT of 0xF4 -> ignored, 0xF4 bits completed unchanged.
REQ-033 rst=0 after edge 5 -> next cycle both oe=0, busy=0, no done pulse.
REQ-034 PS2_TX_TIMEOUT_EN defined, device never clocks -> done=1, err=1 at 2000 cycles after INHIBIT; undefined -> busy remains 1 indefinitely.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, start bit, 8 data bits LSB first, odd parity, stop, ACK.
// Optional watchdog enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       FPGAClk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       PS2Clk_in,
  input  logic       PS2Data_in,
  output logic       PS2Clk_oe,
  output logic       PS2Data_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, START, SHIFT, PARITY, STOP, ACK} state_t;

  state_t        state, state_nxt;
  logic [1:0]    clk_sync, dat_sync;
  logic          clk_prev;
  logic          fall, dat_s, active;
  logic [7:0]    tx_byte;
  logic          par;
  logic [3:0]    ecnt;
  logic [IW-1:0] inh_cnt;
  logic          dat_oe;
  logic          done_nxt, err_nxt;
  logic          wd_hit;

  // Line synchronizers idle high to match released open-drain lines
  always_ff @(posedge FPGAClk) begin
    if (!rst) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], PS2Clk_in};
      dat_sync <= {dat_sync[0], PS2Data_in};
      clk_prev <= clk_sync[1];
    end
  end

  assign fall   = clk_prev & ~clk_sync[1];
  assign dat_s  = dat_sync[1];
  assign active = (state != IDLE) && (state != INHIBIT);

`ifdef PS2_TX_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd;

  always_ff @(posedge FPGAClk) begin
    if (!rst || !active) wd <= '0;
    else                 wd <= wd + 1'b1;
  end

  assign wd_hit = active && (wd == WW'(TIMEOUT_CYCLES - 1));
`else
  assign wd_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    unique case (state)
      IDLE:    if (tx_start) state_nxt = INHIBIT;
      INHIBIT: if (inh_cnt == IW'(INHIBIT_CYCLES - 1)) state_nxt = START;
      START:   if (fall) state_nxt = SHIFT;
      SHIFT:   if (fall && ecnt == 4'd7) state_nxt = PARITY;
      PARITY:  if (fall) state_nxt = STOP;
      STOP:    if (fall) state_nxt = ACK;
      ACK: if (fall) begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
        err_nxt   = dat_s;
      end
      default: state_nxt = IDLE;
    endcase
    // A completing ACK wins over a simultaneous watchdog expiry
    if (wd_hit && state_nxt != IDLE) begin
      state_nxt = IDLE;
      done_nxt  = 1'b1;
      err_nxt   = 1'b1;
    end
  end

  always_ff @(posedge FPGAClk) begin
    if (!rst) begin
      state   <= IDLE;
      tx_byte <= '0;
      par     <= 1'b0;
      ecnt    <= '0;
      inh_cnt <= '0;
      dat_oe  <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
      err   <= err_nxt;
      if (state == IDLE && tx_start) begin
        tx_byte <= tx_data;
        par     <= ~^tx_data;
        ecnt    <= '0;
        inh_cnt <= '0;
      end
      if (state == INHIBIT) inh_cnt <= inh_cnt + 1'b1;
      if (active && fall) ecnt <= ecnt + 1'b1;
      // Data line changes the cycle after the falling edge is seen
      if (state_nxt == IDLE) dat_oe <= 1'b0;
      else begin
        unique case (state)
          INHIBIT:      if (state_nxt == START) dat_oe <= 1'b1;
          START, SHIFT: if (fall) dat_oe <= ~tx_byte[ecnt[2:0]];
          PARITY:       if (fall) dat_oe <= ~par;
          STOP:         if (fall) dat_oe <= 1'b0;
          default:      ;
        endcase
      end
    end
  end

  assign PS2Clk_oe  = (state == INHIBIT);
  assign PS2Data_oe = dat_oe;
  assign busy       = (state != IDLE);

endmodule
